// File: rtl/comparator_seq_ctrl.sv
// Sequential unsigned magnitude comparator: one 2-bit digit slice reused MSB-first,
// with a start/busy/done handshake and registered greater/equal/less flags.
module comparator_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1,
    localparam int DIGITS    = WIDTH / 2,
    localparam int SW        = $clog2(DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  A_in,
    input  logic [WIDTH-1:0]  B_in,
    output logic              busy,
    output logic              done,
    output logic              is_greater,
    output logic              is_equal,
    output logic              is_less,
    output logic [SW-1:0]     steps
);

    // Handshake: start is honoured only in IDLE; busy covers COMPARE and DONE;
    // done is a single-cycle pulse during DONE, when exactly one flag is high.
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [IW-1:0]    idx;
    logic             pend_gt;
    logic             pend_lt;

    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic             dig_gt;
    logic             dig_lt;
    logic             last_digit;
    logic             any_pend;
    logic             res_gt;
    logic             res_lt;

    always_comb begin
        a_shift    = reg_a >> (2 * idx);
        b_shift    = reg_b >> (2 * idx);
        a_dig      = a_shift[1:0];
        b_dig      = b_shift[1:0];
        dig_gt     = (a_dig > b_dig);
        dig_lt     = (a_dig < b_dig);
        last_digit = (idx == '0);
        any_pend   = pend_gt | pend_lt;

        // In full-scan mode the first recorded difference outranks the current digit.
        if (EARLY_EXIT == 0 && any_pend) begin
            res_gt = pend_gt;
            res_lt = pend_lt;
        end else begin
            res_gt = dig_gt;
            res_lt = dig_lt;
        end

        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (last_digit || (EARLY_EXIT != 0 && (dig_gt || dig_lt))) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a      <= '0;
            reg_b      <= '0;
            idx        <= '0;
            steps      <= '0;
            pend_gt    <= 1'b0;
            pend_lt    <= 1'b0;
            is_greater <= 1'b0;
            is_equal   <= 1'b0;
            is_less    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        reg_a      <= A_in;
                        reg_b      <= B_in;
                        idx        <= IW'(DIGITS - 1);
                        steps      <= '0;
                        pend_gt    <= 1'b0;
                        pend_lt    <= 1'b0;
                        is_greater <= 1'b0;
                        is_equal   <= 1'b0;
                        is_less    <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    steps <= steps + 1'b1;
                    if (!any_pend) begin
                        pend_gt <= dig_gt;
                        pend_lt <= dig_lt;
                    end
                    if (state_next == S_DONE) begin
                        is_greater <= res_gt;
                        is_less    <= res_lt;
                        is_equal   <= !(res_gt || res_lt);
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Scoreboard bench for comparator_seq_ctrl: three configurations (8-bit early exit,
// 8-bit full scan, 2-bit) share one stimulus stream and are checked against a behavioural model.
module tb_comparator_seq_ctrl;

    localparam int EW = 22;  // {done edge[15:0], steps[2:0], flags {gt,eq,lt}}
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;

    wire [NDUT-1:0] busy_v;
    wire [NDUT-1:0] done_v;
    wire [NDUT-1:0] gt_v;
    wire [NDUT-1:0] eq_v;
    wire [NDUT-1:0] lt_v;
    wire [2:0]      steps_v [NDUT];

    int cyc = 0;
    int pending = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : cfg
        localparam int W  = (g == 2) ? 2 : 8;
        localparam int EE = (g == 1) ? 0 : 1;
        localparam int D  = W / 2;
        localparam int SW = $clog2(D + 1);

        wire [SW-1:0] steps_w;

        comparator_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(EE)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .A_in       (a_in[W-1:0]),
            .B_in       (b_in[W-1:0]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .is_greater (gt_v[g]),
            .is_equal   (eq_v[g]),
            .is_less    (lt_v[g]),
            .steps      (steps_w)
        );
        assign steps_v[g] = 3'(steps_w);

        logic [EW-1:0] exp_q[$];
        int         free_edge = 0;
        int         acc_edge = 0;
        int         acc_k = 0;
        bit         active = 0;
        logic [2:0] last_flags = '0;
        logic [2:0] last_steps = '0;

        // Digits examined: full scan always reads all D; early exit stops at the first difference.
        function automatic int digits_examined(input logic [7:0] a, input logic [7:0] b);
            if (EE == 0) return D;
            for (int i = D - 1; i >= 0; i--) begin
                if (a[2*i +: 2] != b[2*i +: 2]) return D - i;
            end
            return D;
        endfunction

        always @(posedge clk) begin : model
            logic [7:0] am;
            logic [7:0] bm;
            logic [2:0] fl;
            int k;
            if (!rst && start && cyc >= free_edge) begin
                am = 8'(a_in[W-1:0]);
                bm = 8'(b_in[W-1:0]);
                fl = (am > bm) ? 3'b100 : ((am == bm) ? 3'b010 : 3'b001);
                k = digits_examined(am, bm);
                exp_q.push_back({16'(cyc + k), 3'(k), fl});
                pending++;
                acc_edge  = cyc;
                acc_k     = k;
                active    = 1;
                free_edge = cyc + k + 2;
            end
        end

        always @(posedge rst) begin
            exp_q.delete();
            active     = 0;
            free_edge  = 0;
            last_flags = '0;
            last_steps = '0;
        end

        always @(negedge clk) begin : monitor
            int le;
            logic [EW-1:0] e;
            logic exp_busy;
            le = cyc - 1;
            if (rst) begin
                check("rst_busy", g, 32'(busy_v[g]), 0);
                check("rst_flags", g, {29'd0, gt_v[g], eq_v[g], lt_v[g]}, 0);
            end else begin
                exp_busy = active && le >= acc_edge && le <= acc_edge + acc_k;
                check("busy", g, 32'(busy_v[g]), 32'(exp_busy));
                if (done_v[g]) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_done", g, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        pending--;
                        check("flags", g, {29'd0, gt_v[g], eq_v[g], lt_v[g]}, 32'(e[2:0]));
                        check("steps", g, 32'(steps_v[g]), 32'(e[5:3]));
                        check("done_edge", g, le, 32'(e[21:6]));
                        last_flags = e[2:0];
                        last_steps = e[5:3];
                    end
                end else if (busy_v[g]) begin
                    check("flags_busy", g, {29'd0, gt_v[g], eq_v[g], lt_v[g]}, 0);
                end else begin
                    check("flags_hold", g, {29'd0, gt_v[g], eq_v[g], lt_v[g]}, 32'(last_flags));
                    check("steps_hold", g, 32'(steps_v[g]), 32'(last_steps));
                    if (exp_q.size() > 0 && int'(exp_q[0][21:6]) < le) begin
                        e = exp_q.pop_front();
                        pending--;
                        check("done_missing", g, 0, 1);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        #1;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (pending == 0 && busy_v == '0) ok = 1;
        end
        if (!ok) check("idle_timeout", 0, 0, 1);
    endtask

    task automatic check_all_zero();
        for (int g = 0; g < NDUT; g++) begin
            check("rst_now_busy", g, 32'(busy_v[g]), 0);
            check("rst_now_done", g, 32'(done_v[g]), 0);
            check("rst_now_flags", g, {29'd0, gt_v[g], eq_v[g], lt_v[g]}, 0);
            check("rst_now_steps", g, 32'(steps_v[g]), 0);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int hold;
        int gap;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1 check_all_zero();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'hA5, 8'hA5);
        wait_idle();
        run_op(8'hC0, 8'h40);
        wait_idle();
        run_op(8'h12, 8'h13);
        wait_idle();
        run_op(8'h4F, 8'h70);
        wait_idle();

        // Re-pulse start mid-run with new operands; the original capture must win.
        @(negedge clk);
        #1;
        a_in = 8'h80; b_in = 8'h01; start = 1'b1;
        @(negedge clk);
        #1;
        a_in = 8'h00; b_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        #1;
        a_in = 8'h5A; start = 1'b0;
        wait_idle();

        // Back-to-back operation with start held high.
        @(negedge clk);
        #1;
        a_in = 8'h03; b_in = 8'h02; start = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Abort mid-COMPARE with reset between edges, then recover.
        run_op(8'h12, 8'h13);
        @(posedge clk);
        #3;
        rst = 1'b1;
        pending = 0;
        #1 check_all_zero();
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_op(8'h12, 8'h13);
        wait_idle();

        for (int n = 0; n < 80; n++) begin
            ra = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: rb = 8'($urandom_range(0, 255));
                1: rb = ra;
                default: rb = ra ^ (8'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
            endcase
            @(negedge clk);
            #1;
            a_in = ra; b_in = rb; start = 1'b1;
            hold = $urandom_range(1, 8);
            repeat (hold) @(negedge clk);
            #1;
            start = 1'b0;
            a_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        wait_idle();

        for (int g = 0; g < NDUT; g++) begin
            check("final_idle_busy", g, 32'(busy_v[g]), 0);
        end
        check("final_pending", 0, pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
